spi_rx_fifo: RTL and testbench

SPI_RX_FIFO -- requirements
Module: spi_rx_fifo

---
 rtl/spi_rx_fifo.sv | 111 +++++++++++
 tb/tb_spi_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_fifo.sv
// Receive-side FIFO for an SPI slave: level-handshake write port,
// one-cycle-latency pop port, sticky overflow flag.
module spi_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [15:0] dat_i,
    output logic        wr_req_ack,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        empty,
    output logic        full,
    output logic [4:0]  level,
    output logic        overflow,
    input  logic        clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [4:0]      level_q, level_d;
    logic            empty_q, full_q;
    logic            ovf_q, ovf_d;
    logic            rvalid_q;
    logic [15:0]     rdata_q;
    logic            take, push, pop, drop;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (wr_req) state_d = ACK;
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!wr_req) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ack is registered: it is high exactly while the FSM sits in ACK
    always_comb begin
        take  = (state_q == IDLE) && wr_req;
        ack_d = (state_d == ACK);
    end

    assign pop  = rd_en && !empty_q;
    assign push = take && (!full_q || pop);
    assign drop = take && !push;

    always_comb begin
        level_d = level_q;
        if (push && !pop) level_d = level_q + 5'd1;
        else if (pop && !push) level_d = level_q - 5'd1;
        ovf_d = ovf_q;
        if (drop) ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= 5'd0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 16'h0000;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q  <= rptr_q + 1'b1;
                rdata_q <= mem_q[rptr_q];
            end
            rvalid_q <= pop;
            level_q  <= level_d;
            empty_q  <= (level_d == 5'd0);
            full_q   <= (level_d == 5'(DEPTH));
            ovf_q    <= ovf_d;
        end
    end

    assign wr_req_ack = ack_q;
    assign rd_data    = rdata_q;
    assign rd_valid   = rvalid_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign level      = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Scoreboard bench for spi_rx_fifo: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_spi_rx_fifo;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [15:0] dat_i = 16'h0;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        wr_req_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        overflow;

    spi_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .wr_req     (wr_req),
        .dat_i      (dat_i),
        .wr_req_ack (wr_req_ack),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mq[$];
    logic [15:0] exp_rd[$];
    logic [15:0] last_d = 16'h0;
    bit          m_ovf = 1'b0;
    bit          m_ack = 1'b0;
    bit          started = 1'b0;
    bit          take = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a word offered from an idle handshake is kept when
    // there is room (or a pop frees room on the same edge), else dropped.
    always @(posedge clk_i) begin : model
        bit p;
        bit w;
        if (reset) begin
            mq.delete();
            exp_rd.delete();
            m_ovf  = 1'b0;
            m_ack  = 1'b0;
            last_d = 16'h0;
            take   = 1'b0;
        end else begin
            p = rd_en && (mq.size() > 0);
            w = take && ((mq.size() < DEPTH) || p);
            if (p) exp_rd.push_back(mq.pop_front());
            if (w) mq.push_back(dat_i);
            if (take && !w) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_ack = take;
            take  = 1'b0;
        end
        started = 1'b1;
    end

    always @(negedge clk_i) begin : monitor
        if (started) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("wr_req_ack", 32'(wr_req_ack), 32'(m_ack));
            if (rd_valid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_valid: got spurious pulse data %h expected none",
                             rd_data);
                end else begin
                    last_d = exp_rd.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(last_d));
                end
            end else begin
                chk("rd_valid", 32'(rd_valid), 32'(exp_rd.size() != 0));
                if (exp_rd.size() != 0) last_d = exp_rd.pop_front();
                chk("rd_hold", 32'(rd_data), 32'(last_d));
            end
        end
    end

    task automatic drive(input bit rnd);
        rd_en   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        clr_ovf = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
    endtask

    task automatic cyc(input bit rnd);
        @(negedge clk_i);
        drive(rnd);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic send(input logic [15:0] d, input int hold, input bit rnd);
        @(negedge clk_i);
        wr_req = 1'b1;
        dat_i  = d;
        take   = 1'b1;
        drive(rnd);
        repeat (hold - 1) cyc(rnd);
        cyc(rnd);
        wr_req = 1'b0;
        cyc(rnd);
    endtask

    task automatic pops(input int n);
        repeat (n) begin
            cyc(1'b0);
            rd_en = 1'b1;
        end
        cyc(1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        reset = 1'b0;
        idle(1);

        send(16'hA5C3, 1, 1'b0);
        idle(1);
        pops(1);
        idle(2);

        send(16'h1234, 10, 1'b0);
        pops(1);
        idle(2);

        for (int i = 1; i <= 9; i++) send(16'(i), 1, 1'b0);
        pops(8);
        @(negedge clk_i);
        clr_ovf = 1'b1;
        @(negedge clk_i);
        clr_ovf = 1'b0;
        pops(1);
        idle(1);

        for (int i = 0; i < 8; i++) send(16'h0200 + 16'(i), 1, 1'b0);
        @(negedge clk_i);
        wr_req = 1'b1;
        dat_i  = 16'hBEEF;
        take   = 1'b1;
        rd_en  = 1'b1;
        @(negedge clk_i);
        rd_en  = 1'b0;
        wr_req = 1'b0;
        idle(2);
        pops(8);
        idle(2);

        for (int i = 0; i < 20; i++) begin
            send(16'h0100 + 16'(i), 1, 1'b0);
            pops(1);
        end
        idle(1);
        pops(2);
        idle(2);

        // reset while the handshake is in ACK with three words stored
        send(16'h0301, 1, 1'b0);
        send(16'h0302, 1, 1'b0);
        @(negedge clk_i);
        wr_req = 1'b1;
        dat_i  = 16'h0303;
        take   = 1'b1;
        @(negedge clk_i);
        reset  = 1'b1;
        wr_req = 1'b0;
        @(negedge clk_i);
        reset  = 1'b0;
        idle(2);

        // request still high when reset releases is taken again
        @(negedge clk_i);
        reset  = 1'b1;
        wr_req = 1'b1;
        dat_i  = 16'h0404;
        take   = 1'b1;
        @(negedge clk_i);
        reset  = 1'b0;
        take   = 1'b1;
        repeat (2) @(negedge clk_i);
        wr_req = 1'b0;
        idle(2);
        pops(1);
        idle(2);

        repeat (80) send(16'($urandom), int'($urandom_range(1, 4)), 1'b1);
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        pops(DEPTH + 1);
        idle(2);

        chk("drained", 32'(exp_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
